id_alloc: RTL and testbench
===========================

ID_ALLOC -- requirements
Module: id_alloc

Interface
REQ-001: The block SHALL have parameter ID_WIDTH, default 3, meaning the width of allocated IDs, with a pool of 2**ID_WIDTH IDs.
REQ-002: The block SHALL have parameter MAX_OUT, default 2**ID_WIDTH, meaning the maximum IDs in use at once, legal range 1..2**ID_WIDTH.
REQ-003: The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004: clk_i  input  1  clock; all state on the rising edge.
REQ-005: rst_i  input  1  asynchronous active-high reset.
REQ-006: clr_i  input  1  synchronous clear of all allocation state.
REQ-007: alloc_req_i  input  1  requester asks for a free ID.
REQ-008: alloc_gnt_o  output  1  ID granted this cycle.
REQ-009: alloc_id_o  output  ID_WIDTH  ID handed out; valid when alloc_gnt_o=1.
REQ-010: free_valid_i  input  1  return of one ID this cycle.
REQ-011: free_id_i  input  ID_WIDTH  ID being returned.
REQ-012: free_err_o  output  1  registered pulse: previous-cycle free named an ID not in use.
REQ-013: used_cnt_o  output  ID_WIDTH+1  number of IDs currently in use.
REQ-014: full_o  output  1  used_cnt_o == MAX_OUT.
REQ-015: empty_o  output  1  used_cnt_o == 0.

Function
REQ-016: The block SHALL hold one in-use bit per ID plus a registered count of set bits.
REQ-017: alloc_id_o SHALL combinationally equal the lowest-index ID whose in-use bit is 0, and 0 when none is free.
REQ-018: alloc_gnt_o SHALL be combinational: alloc_req_i & !full_o & !clr_i.
REQ-019: On an alloc handshake, the block SHALL set the in-use bit of alloc_id_o at the next rising edge; grant latency is 0 cycles, with the ID reserved from the next cycle on.
REQ-020: alloc_id_o and alloc_gnt_o SHALL NOT depend on free_valid_i/free_id_i in the same cycle; a freed ID becomes grantable from the next cycle.
REQ-021: A free of an in-use ID SHALL clear its bit at the next edge and decrement used_cnt_o.
REQ-022: A free of an ID not in use SHALL leave state unchanged and assert free_err_o for exactly one cycle in the following cycle.
REQ-023: Simultaneous alloc handshake and valid free of a different ID SHALL both take effect, leaving used_cnt_o unchanged.
REQ-024: Simultaneous alloc handshake and free of the same ID (not in use) SHALL grant the ID, set the bit, and flag free_err_o.
REQ-025: used_cnt_o SHALL never exceed MAX_OUT and never underflow below 0.
REQ-026: At full, alloc_req_i SHALL be held off (alloc_gnt_o=0) with no state change, and the requester may keep alloc_req_i high.
REQ-027: When MAX_OUT < 2**ID_WIDTH, full_o SHALL assert at MAX_OUT even though free IDs remain.
REQ-028: clr_i SHALL clear all in-use bits and used_cnt_o at the next edge, overriding a same-cycle alloc or free.
REQ-029: While clr_i is high, the block SHALL not raise free_err_o for that cycle's free.

Reset
REQ-030: While rst_i is asserted, the block SHALL asynchronously clear all in-use bits and used_cnt_o.
REQ-031: After reset, outputs SHALL be: used_cnt_o=0, empty_o=1, full_o=0, free_err_o=0, alloc_id_o=0, and alloc_gnt_o=alloc_req_i.
REQ-032: Reset mid-operation SHALL discard all outstanding IDs, and frees of them afterwards SHALL flag free_err_o.

Verification (ID_WIDTH=2, MAX_OUT=4 unless stated)
REQ-033: Four back-to-back alloc requests from reset -> IDs 0,1,2,3 granted on consecutive cycles; fifth cycle: alloc_gnt_o=0, full_o=1, used_cnt_o=4.
REQ-034: Starting full, free ID 1 -> alloc_gnt_o stays 0 that cycle; next cycle alloc_id_o=1 and alloc_gnt_o=1.
REQ-035: IDs 0,1 in use, alloc handshake and free ID 0 in the same cycle -> ID 2 granted, used_cnt_o stays 2, bits {1,2} set.
REQ-036: Free ID 3 while not in use -> free_err_o=1 for exactly one cycle, used_cnt_o unchanged.
REQ-037: MAX_OUT=2 and two allocs -> full_o=1 with IDs 2,3 free, and a third request is not granted.
REQ-038: rst_i pulsed with 3 IDs in use -> used_cnt_o=0 immediately (asynchronously); after release, next grant returns ID 0.

Source files
------------

// File: rtl/id_alloc.sv
// id_alloc: pool allocator for 2**ID_WIDTH identifiers.
//
// Each identifier has one in-use bit. A registered count of set bits drives
// the used/full/empty outputs. A request is granted in the same cycle it is
// made, and the granted ID is the lowest-index ID that is not in use. The ID
// counts as reserved from the next cycle on. An ID that is returned becomes
// grantable again from the next cycle. Returning an ID that is not in use
// leaves the state alone and raises a one-cycle error pulse in the cycle
// after the bad return.
//
// Ports
//   clk_i         clock; all state changes on the rising edge
//   rst_i         asynchronous active-high reset
//   clr_i         synchronous clear of all allocation state
//   alloc_req_i   requester asks for a free ID
//   alloc_gnt_o   ID granted this cycle (combinational)
//   alloc_id_o    lowest free ID (combinational); 0 when none is free
//   free_valid_i  one ID is returned this cycle
//   free_id_i     ID being returned
//   free_err_o    registered pulse: the previous cycle's return named an ID
//                 that was not in use
//   used_cnt_o    number of IDs currently in use
//   full_o        used_cnt_o == MAX_OUT
//   empty_o       used_cnt_o == 0
module id_alloc #(
  parameter int ID_WIDTH = 3,
  parameter int MAX_OUT  = 2**ID_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                alloc_req_i,
  output logic                alloc_gnt_o,
  output logic [ID_WIDTH-1:0] alloc_id_o,
  input  logic                free_valid_i,
  input  logic [ID_WIDTH-1:0] free_id_i,
  output logic                free_err_o,
  output logic [ID_WIDTH:0]   used_cnt_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int NUM_IDS = 2**ID_WIDTH;
  localparam logic [ID_WIDTH:0]  MAX_CNT  = (ID_WIDTH+1)'(MAX_OUT);
  localparam logic [NUM_IDS-1:0] ONE_HOT0 = {{(NUM_IDS-1){1'b0}}, 1'b1};

  // Return the lowest-index clear bit, or 0 when every bit is set.
  // The scan runs from high to low, so the last hit is the lowest index.
  function automatic logic [ID_WIDTH-1:0] lowest_free(input logic [NUM_IDS-1:0] used);
    logic [ID_WIDTH-1:0] res;
    res = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (!used[i]) begin
        res = ID_WIDTH'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [NUM_IDS-1:0]  used_r;
  logic [ID_WIDTH:0]   cnt_r;
  logic                full_r;
  logic                empty_r;
  logic                free_err_r;

  logic [ID_WIDTH-1:0] alloc_id_s;
  logic                alloc_gnt_s;
  logic                free_hit_s;
  logic [NUM_IDS-1:0]  set_mask_s;
  logic [NUM_IDS-1:0]  clr_mask_s;
  logic [NUM_IDS-1:0]  used_nxt_s;
  logic [ID_WIDTH:0]   cnt_nxt_s;
  logic                err_nxt_s;

  // The grant path looks only at the registered state. It therefore never
  // sees a return made in the same cycle.
  assign alloc_id_s  = lowest_free(used_r);
  assign alloc_gnt_s = alloc_req_i & ~full_r & ~clr_i;
  assign free_hit_s  = free_valid_i & used_r[free_id_i];

  // Work out the next in-use bits, the next count and the next error flag.
  always_comb begin
    set_mask_s = alloc_gnt_s ? (ONE_HOT0 << alloc_id_s) : '0;
    // The granted ID is free and the hit ID is in use, so the two masks
    // never overlap.
    clr_mask_s = free_hit_s ? (ONE_HOT0 << free_id_i) : '0;
    used_nxt_s = used_r;
    cnt_nxt_s  = cnt_r;
    err_nxt_s  = 1'b0;
    if (clr_i) begin
      used_nxt_s = '0;
      cnt_nxt_s  = '0;
      err_nxt_s  = 1'b0;
    end else begin
      used_nxt_s = (used_r | set_mask_s) & ~clr_mask_s;
      err_nxt_s  = free_valid_i & ~used_r[free_id_i];
      case ({alloc_gnt_s, free_hit_s})
        2'b10:   cnt_nxt_s = cnt_r + (ID_WIDTH+1)'(1);
        2'b01:   cnt_nxt_s = cnt_r - (ID_WIDTH+1)'(1);
        default: cnt_nxt_s = cnt_r;
      endcase
    end
  end

  // Allocation state. The full and empty flags are registered together with
  // the count they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      used_r     <= '0;
      cnt_r      <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      free_err_r <= 1'b0;
    end else begin
      used_r     <= used_nxt_s;
      cnt_r      <= cnt_nxt_s;
      full_r     <= (cnt_nxt_s == MAX_CNT);
      empty_r    <= (cnt_nxt_s == (ID_WIDTH+1)'(0));
      free_err_r <= err_nxt_s;
    end
  end

  assign alloc_gnt_o = alloc_gnt_s;
  assign alloc_id_o  = alloc_id_s;
  assign free_err_o  = free_err_r;
  assign used_cnt_o  = cnt_r;
  assign full_o      = full_r;
  assign empty_o     = empty_r;

endmodule

// File: tb/tb_id_alloc.sv
// Bench for id_alloc with ID_WIDTH=2. The main instance uses MAX_OUT=4 and a
// second instance uses MAX_OUT=2. A reference model predicts the outputs.
// The prediction is queued when the stimulus is driven and popped when the
// outputs are sampled. Scenario checks compare against fixed constants.
module tb_id_alloc;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       req;
  logic       fv;
  logic [1:0] fid;
  logic       gnt;
  logic [1:0] id;
  logic       err;
  logic [2:0] cnt;
  logic       full;
  logic       empty;

  logic       b_clr;
  logic       b_req;
  logic       b_fv;
  logic [1:0] b_fid;
  logic       b_gnt;
  logic [1:0] b_id;
  logic       b_err;
  logic [2:0] b_cnt;
  logic       b_full;
  logic       b_empty;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       gnt;
    logic [1:0] id;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_used;
  logic       m_err;

  id_alloc #(.ID_WIDTH(2), .MAX_OUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .alloc_req_i(req),
    .alloc_gnt_o(gnt), .alloc_id_o(id), .free_valid_i(fv), .free_id_i(fid),
    .free_err_o(err), .used_cnt_o(cnt), .full_o(full), .empty_o(empty)
  );

  id_alloc #(.ID_WIDTH(2), .MAX_OUT(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .clr_i(b_clr), .alloc_req_i(b_req),
    .alloc_gnt_o(b_gnt), .alloc_id_o(b_id), .free_valid_i(b_fv), .free_id_i(b_fid),
    .free_err_o(b_err), .used_cnt_o(b_cnt), .full_o(b_full), .empty_o(b_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus just after the falling edge. Queue the
  // model's prediction, then compare the sampled outputs against it. Finally
  // advance the model to its state after the next rising edge.
  task automatic step(input logic r, input logic f, input logic [1:0] fi, input logic c);
    exp_t e;
    exp_t got;
    int   ones;
    logic [1:0] lf;
    @(negedge clk);
    req = r; fv = f; fid = fi; clr = c;
    #1;
    ones = $countones(m_used);
    lf = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!m_used[i]) begin
        lf = 2'(i);
        break;
      end
    end
    e.cnt   = 3'(ones);
    e.full  = (ones == 4);
    e.empty = (ones == 0);
    e.id    = lf;
    e.gnt   = r && (ones != 4) && !c;
    e.err   = m_err;
    sb.push_back(e);

    got = sb.pop_front();
    check("gnt",   int'(gnt),   int'(got.gnt));
    check("id",    int'(id),    int'(got.id));
    check("cnt",   int'(cnt),   int'(got.cnt));
    check("full",  int'(full),  int'(got.full));
    check("empty", int'(empty), int'(got.empty));
    check("err",   int'(err),   int'(got.err));

    if (c) begin
      m_used = 4'b0000;
      m_err  = 1'b0;
    end else begin
      m_err = f && !m_used[fi];
      if (f && m_used[fi]) m_used[fi] = 1'b0;
      if (e.gnt) m_used[lf] = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req = 1'b0; fv = 1'b0; fid = 2'd0;
    b_clr = 1'b0; b_req = 1'b0; b_fv = 1'b0; b_fid = 2'd0;
    m_used = 4'b0000; m_err = 1'b0;
    #1;
    check("rst_cnt",   int'(cnt),   0);
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full),  0);
    check("rst_err",   int'(err),   0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Idle, then four back-to-back grants from reset, then held off at full.
    step(1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 2'd0, 1'b0);
      check("b2b_gnt", int'(gnt), 1);
      check("b2b_id",  int'(id),  i);
    end
    step(1'b1, 1'b0, 2'd0, 1'b0);
    check("full_gnt", int'(gnt),  0);
    check("full_flg", int'(full), 1);
    check("full_cnt", int'(cnt),  4);

    // Return ID 1 while full: no grant that cycle, ID 1 granted the next.
    step(1'b1, 1'b1, 2'd1, 1'b0);
    check("frfull_gnt", int'(gnt), 0);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    check("refill_gnt", int'(gnt), 1);
    check("refill_id",  int'(id),  1);

    // Reduce to IDs {0,1}, then grant and return ID 0 in the same cycle.
    step(1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b0, 1'b1, 2'd3, 1'b0);
    step(1'b1, 1'b1, 2'd0, 1'b0);
    check("swap_id",  int'(id),  2);
    check("swap_gnt", int'(gnt), 1);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("swap_cnt", int'(cnt), 2);
    check("swap_lf",  int'(id),  0);

    // Return ID 3, which is not in use: one-cycle error pulse.
    step(1'b0, 1'b1, 2'd3, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("bad_err1", int'(err), 1);
    check("bad_cnt",  int'(cnt), 2);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("bad_err0", int'(err), 0);

    // Grant ID 0 and return ID 0 (not in use) in the same cycle.
    step(1'b1, 1'b1, 2'd0, 1'b0);
    check("same_id", int'(id), 0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("same_err", int'(err), 1);
    check("same_cnt", int'(cnt), 3);

    // A clear overrides a same-cycle grant and a bad return.
    step(1'b1, 1'b1, 2'd3, 1'b1);
    check("clr_gnt", int'(gnt), 0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("clr_cnt", int'(cnt), 0);
    check("clr_err", int'(err), 0);

    // Reset in the middle of a cycle with three IDs in use.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("pre_rst_cnt", int'(cnt), 3);
    #1;
    rst = 1'b1;
    #1;
    check("arst_cnt",   int'(cnt),   0);
    check("arst_empty", int'(empty), 1);
    m_used = 4'b0000; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 2'd0, 1'b0);
    check("post_rst_id", int'(id), 0);
    step(1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("stale_err", int'(err), 1);

    // Random traffic, checked against the model.
    for (int n = 0; n < 60; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0));
    end
    step(1'b0, 1'b0, 2'd0, 1'b1);

    // MAX_OUT=2 instance: full after two grants while IDs 2 and 3 are free.
    @(negedge clk);
    b_req = 1'b1;
    #1;
    check("b_gnt0", int'(b_gnt), 1);
    check("b_id0",  int'(b_id),  0);
    @(negedge clk); #1;
    check("b_gnt1", int'(b_gnt), 1);
    check("b_id1",  int'(b_id),  1);
    @(negedge clk); #1;
    check("b_full", int'(b_full), 1);
    check("b_gnt2", int'(b_gnt),  0);
    check("b_id2",  int'(b_id),   2);
    check("b_cnt",  int'(b_cnt),  2);
    b_req = 1'b0;

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
